// File: rtl/xg_lane_loopback.sv
// xg_lane_loopback: per-lane bypass, near-end loopback and PRBS7 link test between core and SERDES
//   sys_clk, reset (sync, active-high) | mode 00 bypass, 01 loopback, 10 PRBS, 11 bypass
//   delay: extra loopback delay | tx_data_in/tx_data_out: core -> serializer
//   rx_data_in/rx_data_out: deserializer -> core | clr_err: clear all error counters
//   lane_locked: per-lane PRBS lock | err_cnt: per-lane errored-word counters
//   XG_ERR_INJECT_EN adds err_inject (flips bit 0 of lane 0 of the next PRBS word)
module xg_lane_loopback #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W = 8,
  parameter int DELAY_DEPTH = 16,
  parameter int ERR_CNT_W = 16,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  localparam int DLY_W = $clog2(DELAY_DEPTH),
  localparam int W = NUM_LANES * LANE_W
) (
  input  logic                           sys_clk,
  input  logic                           reset,
  input  logic [1:0]                     mode,
  input  logic [DLY_W-1:0]               delay,
  input  logic [W-1:0]                   tx_data_in,
  output logic [W-1:0]                   tx_data_out,
  input  logic [W-1:0]                   rx_data_in,
  output logic [W-1:0]                   rx_data_out,
  input  logic                           clr_err,
`ifdef XG_ERR_INJECT_EN
  input  logic                           err_inject,
`endif
  output logic [NUM_LANES-1:0]           lane_locked,
  output logic [NUM_LANES*ERR_CNT_W-1:0] err_cnt
);
  localparam int CLEAN_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W = $clog2(LOSS_CNT + 1);
  typedef enum logic {HUNT, LOCKED} state_t;

  logic [1:0] mode_q;
  logic mode_chg, lb, prbs;
  assign mode_chg = mode != mode_q;
  assign lb = mode == 2'b01;
  assign prbs = mode == 2'b10;

  // Delay line: entries older than the fill count (or any entry on a mode change) read as zero.
  logic [W-1:0] mem [DELAY_DEPTH];
  logic [DLY_W-1:0] wr_ptr;
  logic [DLY_W:0] fill;
  logic [W-1:0] dl_word;
  assign dl_word = ~|delay ? tx_data_in :
                   (!mode_chg && fill >= {1'b0, delay}) ? mem[wr_ptr - delay] : '0;

  // All lanes share seed and step count, so one generator feeds every lane.
  logic [6:0] gen_q, gen_s;
  logic [LANE_W-1:0] gen_word;
  logic [W-1:0] inj;
  always_comb begin
    gen_s = mode_chg ? 7'h7F : gen_q;
    gen_word = '0;
    for (int k = LANE_W - 1; k >= 0; k--) begin
      gen_word[k] = gen_s[6] ^ gen_s[5];
      gen_s = {gen_s[5:0], gen_s[6] ^ gen_s[5]};
    end
  end

`ifdef XG_ERR_INJECT_EN
  assign inj = W'(err_inject);
`else
  assign inj = '0;
`endif

  // Self-synchronising checker: each bit is predicted from the previously received bits.
  logic [6:0] hist_q [NUM_LANES], hist_d [NUM_LANES];
  logic [NUM_LANES-1:0] word_err;
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      hist_d[l] = hist_q[l];
      word_err[l] = 1'b0;
      for (int k = LANE_W - 1; k >= 0; k--) begin
        word_err[l] = word_err[l] | (rx_data_in[l*LANE_W + k] != (hist_d[l][6] ^ hist_d[l][5]));
        hist_d[l] = {hist_d[l][5:0], rx_data_in[l*LANE_W + k]};
      end
    end
  end

  state_t state_q [NUM_LANES], state_d [NUM_LANES];
  logic [CLEAN_W-1:0] clean_q [NUM_LANES], clean_d [NUM_LANES];
  logic [LOSS_W-1:0] loss_q [NUM_LANES], loss_d [NUM_LANES];
  logic [ERR_CNT_W-1:0] err_q [NUM_LANES], err_d [NUM_LANES];
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      state_d[l] = state_q[l];
      clean_d[l] = clean_q[l];
      loss_d[l] = loss_q[l];
      err_d[l] = err_q[l];
      if (!prbs || mode_chg) begin
        state_d[l] = HUNT;
        clean_d[l] = '0;
        loss_d[l] = '0;
      end else if (state_q[l] == HUNT) begin
        clean_d[l] = word_err[l] ? '0 : clean_q[l] + 1'b1;
        if (!word_err[l] && clean_q[l] == CLEAN_W'(LOCK_CNT - 1)) begin
          state_d[l] = LOCKED;
          clean_d[l] = '0;
        end
      end else if (word_err[l]) begin
        err_d[l] = &err_q[l] ? err_q[l] : err_q[l] + 1'b1;
        loss_d[l] = loss_q[l] + 1'b1;
        if (loss_q[l] == LOSS_W'(LOSS_CNT - 1)) begin
          state_d[l] = HUNT;
          loss_d[l] = '0;
        end
      end else begin
        loss_d[l] = '0;
      end
      if (clr_err) err_d[l] = '0;
    end
  end

  always_comb begin
    lane_locked = '0;
    err_cnt = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_locked[l] = state_q[l] == LOCKED;
      err_cnt[l*ERR_CNT_W +: ERR_CNT_W] = err_q[l];
    end
  end

  always_ff @(posedge sys_clk) mem[wr_ptr] <= tx_data_in;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      mode_q <= '0;
      wr_ptr <= '0;
      fill <= '0;
      gen_q <= 7'h7F;
      tx_data_out <= '0;
      rx_data_out <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        state_q[l] <= HUNT;
        clean_q[l] <= '0;
        loss_q[l] <= '0;
        err_q[l] <= '0;
        hist_q[l] <= '0;
      end
    end else begin
      mode_q <= mode;
      wr_ptr <= wr_ptr + 1'b1;
      fill <= mode_chg ? '0 : fill == (DLY_W+1)'(DELAY_DEPTH) ? fill : fill + 1'b1;
      gen_q <= gen_s;
      tx_data_out <= prbs ? {NUM_LANES{gen_word}} ^ inj : tx_data_in;
      rx_data_out <= lb ? dl_word : rx_data_in;
      for (int l = 0; l < NUM_LANES; l++) begin
        state_q[l] <= state_d[l];
        clean_q[l] <= clean_d[l];
        loss_q[l] <= loss_d[l];
        err_q[l] <= err_d[l];
        hist_q[l] <= hist_d[l];
      end
    end
  end
endmodule

// File: tb/tb_xg_lane_loopback.sv
// tb_xg_lane_loopback: table, directed and random checks of xg_lane_loopback against a reference model
module tb_xg_lane_loopback;
  localparam int NL = 4, W = 32, EW = 4, DD = 16, LOCK = 16, LOSS = 4;
  localparam int EMAX = (1 << EW) - 1;

  logic sys_clk = 1'b0;
  logic reset, clr_err;
  logic [1:0] mode;
  logic [3:0] delay;
  logic [W-1:0] tx_data_in, tx_data_out, rx_data_in, rx_data_out;
  logic [NL-1:0] lane_locked;
  logic [NL*EW-1:0] err_cnt;
`ifdef XG_ERR_INJECT_EN
  logic err_inject = 1'b0;
`endif

  always #5 sys_clk = ~sys_clk;

  xg_lane_loopback #(.ERR_CNT_W(EW)) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .mode(mode),
    .delay(delay),
    .tx_data_in(tx_data_in),
    .tx_data_out(tx_data_out),
    .rx_data_in(rx_data_in),
    .rx_data_out(rx_data_out),
    .clr_err(clr_err),
`ifdef XG_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .lane_locked(lane_locked),
    .err_cnt(err_cnt)
  );

  typedef struct {
    logic [1:0] mode;
    logic [3:0] dly;
    logic [W-1:0] tx, rx, etx, erx;
  } vec_t;
  vec_t tbl [7];

  int nvec = 0, nbad = 0;
  bit seq [127];
  int pos;
  logic [W-1:0] lbq [$];
  logic [1:0] mq;
  logic [6:0] hb [NL];
  int m_lock [NL], m_clean [NL], m_loss [NL], m_err [NL];
  logic [W-1:0] e_tx, e_rx;
  bit tie;
  logic [W-1:0] cor;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] prbs_word(input int p);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[7-j] = seq[(8 * p + j) % 127];
    return w;
  endfunction

  task automatic model_edge();
    bit chg, b, errd;
    int d;
    if (reset) begin
      mq = 2'b00; pos = 0; lbq.delete(); e_tx = '0; e_rx = '0;
      for (int l = 0; l < NL; l++) begin
        hb[l] = '0; m_lock[l] = 0; m_clean[l] = 0; m_loss[l] = 0; m_err[l] = 0;
      end
      return;
    end
    chg = mode != mq;
    if (chg) begin
      pos = 0;
      lbq.delete();
    end
    if (mode == 2'b10) begin
      for (int l = 0; l < NL; l++) e_tx[l*8 +: 8] = prbs_word(pos);
      pos = (pos + 1) % 127;
    end else e_tx = tx_data_in;
    d = int'(delay);
    if (mode == 2'b01)
      e_rx = (d == 0) ? tx_data_in : (lbq.size() >= d) ? lbq[lbq.size() - d] : '0;
    else e_rx = rx_data_in;
    if (!chg) begin
      lbq.push_back(tx_data_in);
      if (lbq.size() > DD) void'(lbq.pop_front());
    end
    for (int l = 0; l < NL; l++) begin
      errd = 0;
      for (int j = 7; j >= 0; j--) begin
        b = rx_data_in[l*8 + j];
        if (b != (hb[l][6] ^ hb[l][5])) errd = 1;
        hb[l] = {hb[l][5:0], b};
      end
      if (chg || mode != 2'b10) begin
        m_lock[l] = 0; m_clean[l] = 0; m_loss[l] = 0;
      end else if (m_lock[l] == 0) begin
        if (errd) m_clean[l] = 0;
        else begin
          m_clean[l]++;
          if (m_clean[l] == LOCK) begin m_lock[l] = 1; m_clean[l] = 0; end
        end
      end else if (errd) begin
        if (m_err[l] < EMAX) m_err[l]++;
        m_loss[l]++;
        if (m_loss[l] == LOSS) begin m_lock[l] = 0; m_loss[l] = 0; end
      end else m_loss[l] = 0;
      if (clr_err) m_err[l] = 0;
    end
    mq = mode;
  endtask

  task automatic compare_all();
    logic [NL-1:0] el;
    logic [NL*EW-1:0] ee;
    for (int l = 0; l < NL; l++) begin
      el[l] = m_lock[l] != 0;
      ee[l*EW +: EW] = EW'(m_err[l]);
    end
    chk("tx_data_out", tx_data_out, e_tx);
    chk("rx_data_out", rx_data_out, e_rx);
    chk("lane_locked", W'(lane_locked), W'(el));
    chk("err_cnt", W'(err_cnt), W'(ee));
  endtask

  task automatic step();
    if (tie) rx_data_in = tx_data_out ^ cor;
    @(posedge sys_clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int bb [134];
    for (int i = 0; i < 7; i++) bb[i] = 1;
    for (int i = 7; i < 134; i++) bb[i] = bb[i-7] ^ bb[i-6];
    for (int i = 0; i < 127; i++) seq[i] = bb[i+7] != 0;

    tbl[0] = '{2'b00, 4'd0, 32'hA5A5_0001, 32'h1234_5678, 32'hA5A5_0001, 32'h1234_5678};
    tbl[1] = '{2'b00, 4'd0, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF};
    tbl[2] = '{2'b11, 4'd0, 32'h1122_3344, 32'h5566_7788, 32'h1122_3344, 32'h5566_7788};
    tbl[3] = '{2'b11, 4'd0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    tbl[4] = '{2'b01, 4'd0, 32'h0102_0304, 32'h9999_9999, 32'h0102_0304, 32'h0102_0304};
    tbl[5] = '{2'b01, 4'd0, 32'h0A0B_0C0D, 32'h0000_0000, 32'h0A0B_0C0D, 32'h0A0B_0C0D};
    tbl[6] = '{2'b00, 4'd0, 32'h0000_0000, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001};

    reset = 1; mode = 0; delay = 0; tx_data_in = 0; rx_data_in = 0; clr_err = 0; tie = 0; cor = 0;
    step(); step();
    chk("reset_tx", tx_data_out, 0);
    chk("reset_rx", rx_data_out, 0);
    chk("reset_lock", W'(lane_locked), 0);
    chk("reset_err", W'(err_cnt), 0);
    reset = 0;

    for (int i = 0; i < 7; i++) begin
      mode = tbl[i].mode; delay = tbl[i].dly; tx_data_in = tbl[i].tx; rx_data_in = tbl[i].rx;
      step();
      chk("tbl_tx", tx_data_out, tbl[i].etx);
      chk("tbl_rx", rx_data_out, tbl[i].erx);
    end

    mode = 0; step();
    mode = 1; delay = 5; tx_data_in = 32'hFF; step();
    for (int k = 1; k <= 24; k++) begin
      tx_data_in = k; step();
      chk("lb_dly5", rx_data_out, (k >= 6) ? W'(k - 5) : '0);
    end
    mode = 0; step();
    mode = 1; delay = 15; tx_data_in = 32'hFF; step();
    for (int k = 1; k <= 40; k++) begin
      tx_data_in = k; step();
      chk("lb_dly15", rx_data_out, (k >= 16) ? W'(k - 15) : '0);
    end

    reset = 1; step();
    chk("midrst_tx", tx_data_out, 0);
    chk("midrst_rx", rx_data_out, 0);
    chk("midrst_lock", W'(lane_locked), 0);
    chk("midrst_err", W'(err_cnt), 0);
    reset = 0;

    mode = 2; tx_data_in = 0; tie = 1; step();
    for (int i = 1; i <= 16; i++) step();
    chk("prelock", W'(lane_locked), 0);
    step();
    chk("lock", W'(lane_locked), 4'hF);
    for (int i = 0; i < 1000; i++) step();
    chk("soak_err", W'(err_cnt), 0);
    chk("soak_lock", W'(lane_locked), 4'hF);

    cor = 32'h0080_0000; step(); cor = 0;
    chk("single_err", W'(err_cnt), 16'h0100);
    chk("single_lock", W'(lane_locked), 4'hF);
    step(); step(); step();
    for (int i = 1; i <= 4; i++) begin
      cor = 32'h0080_0000; step();
      chk("burst_err", W'(err_cnt), W'(16'h0100 + 16'h0100 * i));
      chk("burst_lock", W'(lane_locked), (i == 4) ? 4'hB : 4'hF);
    end
    cor = 0;
    for (int i = 0; i < 60 && lane_locked != 4'hF; i++) step();
    chk("relock", W'(lane_locked), 4'hF);

    for (int i = 0; i < 20; i++) begin
      cor = 32'h0080_0000; step();
      cor = 0; step();
    end
    chk("sat_err", W'(err_cnt), 16'h0F00);
    chk("sat_lock", W'(lane_locked), 4'hF);
    cor = 32'h0080_0000; clr_err = 1; step();
    chk("clr_err", W'(err_cnt), 0);
    chk("clr_lock", W'(lane_locked), 4'hF);
    cor = 0; clr_err = 0; step();
    cor = 32'h0080_0000; step(); cor = 0;
    chk("pre_chg_err", W'(err_cnt), 16'h0100);

    mode = 1; delay = 3; tie = 0; tx_data_in = $urandom; step();
    chk("chg_lock", W'(lane_locked), 0);
    chk("chg_rx", rx_data_out, 0);
    chk("chg_err", W'(err_cnt), 16'h0100);
    for (int k = 1; k <= 6; k++) begin
      tx_data_in = $urandom; step();
    end

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 400) == 0;
      if ($urandom % 80 == 0) mode = 2'($urandom);
      if ($urandom % 16 == 0) delay = 4'($urandom);
      tx_data_in = $urandom;
      clr_err = ($urandom % 64) == 0;
      tie = mode == 2'b10;
      cor = ($urandom % 30 == 0) ? (32'h1 << ($urandom % 32)) : '0;
      if (!tie) rx_data_in = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/xg_lane_loopback.md
Name: xg_lane_loopback

Overview:
- Parametrised per-lane loopback and link-test block between the XGMII-side core and the lane SERDES interface; generalises plain external TX-to-RX wiring.
- Three modes per instance: registered bypass, near-end loopback with programmable delay, and per-lane PRBS7 generate/check with lock tracking and error counting.
- Used for board bring-up and in-system link qualification without external loopback hardware.

Parameters:
- NUM_LANES, 4, number of lanes.
- LANE_W, 8, bits per lane per clock.
- DELAY_DEPTH, 16, loopback delay-line entries; power of two, at least 2; DLY_W = $clog2(DELAY_DEPTH).
- ERR_CNT_W, 16, per-lane error counter width.
- LOCK_CNT, 16, consecutive clean words required to lock.
- LOSS_CNT, 4, consecutive errored words that drop lock.

Ports:
- sys_clk  in  1  single block clock.
- reset  in  1  synchronous, active-high.
- mode  in  2  00 bypass, 01 loopback, 10 PRBS, 11 reserved (treated as bypass).
- delay  in  DLY_W  extra loopback delay in cycles.
- tx_data_in  in  NUM_LANES*LANE_W  from core; lane i occupies bits [i*LANE_W +: LANE_W].
- tx_data_out  out  NUM_LANES*LANE_W  to serializer.
- rx_data_in  in  NUM_LANES*LANE_W  from deserializer.
- rx_data_out  out  NUM_LANES*LANE_W  to core.
- clr_err  in  1  clears all error counters.
- lane_locked  out  NUM_LANES  per-lane PRBS lock flag.
- err_cnt  out  NUM_LANES*ERR_CNT_W  per-lane errored-word counters.

Behaviour:
- Reset: every output is 0; delay-line fill count is 0; all checkers are in HUNT; PRBS generators are seeded to 7'h7F; counters are 0.
- All outputs are registered.
- Bypass:
  - tx_data_out(t+1) = tx_data_in(t).
  - rx_data_out(t+1) = rx_data_in(t).
- Loopback:
  - tx_data_out behaves as in bypass.
  - rx_data_out(t) = tx_data_in(t-1-delay).
  - The delay line is a circular buffer of DELAY_DEPTH entries; the write pointer advances every cycle.
  - Read address = wr_ptr - delay, modulo DELAY_DEPTH (wrap-around).
  - Any entry not yet written since the last flush reads as 0. A fill counter saturating at DELAY_DEPTH tracks this.
  - A change of delay takes effect on the next cycle with no flush. Output may repeat or skip words at that boundary; this is accepted.
- PRBS:
  - Each lane's generator runs PRBS7 (x^7+x^6+1) and emits LANE_W bits per cycle, MSB first in time.
  - The generator advances LANE_W steps per clock.
  - tx_data_out carries the generator output.
  - rx_data_out = rx_data_in registered (1 cycle).
- Checker (self-synchronising, per lane):
  - Each received bit b is predicted as h[6]^h[5], where h holds the last 7 received bits, carried across words.
  - A word is errored if any bit mismatches.
  - FSM HUNT: clean counter increments on a clean word and clears on an errored word. Reaching LOCK_CNT clean words moves to LOCKED, and lane_locked rises on the same edge.
  - FSM LOCKED: an errored word increments err_cnt (saturating at all-ones) and the loss counter. A clean word clears the loss counter. Reaching LOSS_CNT consecutive errored words moves to HUNT, and lane_locked falls.
  - err_cnt never increments in HUNT.
- clr_err:
  - Zeroes all err_cnt fields next cycle.
  - If asserted in the same cycle as an increment, the clear wins (result 0).
  - Lock state is not affected.
- Mode change (mode differs from its registered copy):
  - Flushes the delay line (fill count = 0).
  - Returns all checkers to HUNT.
  - Reseeds generators to 7'h7F.
  - err_cnt is retained.
  - New-mode data appears from the following cycle.
- Reset asserted mid-operation overrides all of the above on the next edge.

Optional Feature:
- Macro XG_ERR_INJECT_EN.
- When defined:
  - Adds input port err_inject (1 bit, placed after clr_err).
  - In PRBS mode, a pulse inverts bit 0 of lane 0 of the next tx_data_out word only.
  - A pulse held high injects into every cycle.
  - Ignored in other modes.
- When undefined: the port and its logic are absent, and generator output is never modified.

Test Plan:
- Bypass: mode=00, tx_data_in=32'hA5A5_0001 for one cycle → tx_data_out=32'hA5A5_0001 exactly 1 cycle later; rx_data_in=32'h1234_5678 → rx_data_out=32'h1234_5678 1 cycle later.
- Loopback delay: mode=01, delay=5, incrementing tx_data_in 1,2,3,… → rx_data_out is 0 for 6 cycles after entry, then 1,2,3… with a 6-cycle offset. Repeat with delay=15 (the pointer wraps) → 16-cycle offset.
- PRBS lock: mode=10, rx_data_in tied to tx_data_out → each lane_locked bit rises 16 clean words after the checker sees valid data; err_cnt stays 0 for 1000 cycles.
- Error count and loss: while locked, flip one bit of lane 2 for 1 word → err_cnt lane2=1, lane still locked. Corrupt lane 2 for 4 consecutive words → lane_locked[2]=0, and err_cnt lane2 increments to 5 total before HUNT.
- Clear/saturation: with ERR_CNT_W=4, force 20 errored words interleaved with clean words → counter holds 15. Assert clr_err simultaneously with an errored word → counter reads 0.
- Reset and mode change: assert reset mid-loopback → all outputs 0 next cycle. Switch mode 10→01 while locked → lane_locked=0 next cycle, delay line reads 0 until refilled.
